mac_window_collector: RTL and testbench



---
 rtl/mac_window_collector.sv | 199 +++++++++++++++++++
 tb/tb_mac_window_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_window_collector.sv
// ---------------------------------------------------------------------------
// mac_window_collector
//
// Sits behind the multiply-accumulate stage and condenses its registered
// accumulator output into frames. Every WINDOW accepted samples produce one
// frame holding the unsigned sum and the unsigned maximum of that window.
// Frames are queued in a small show-ahead FIFO and drained with a
// valid/ready handshake.
//
// Handshakes (both sides): a transfer happens in exactly the cycles where
// valid && ready are both high at the rising clock edge. Valid never waits
// on ready. in_ready is a pure function of the FSM state and does not look at
// in_valid. out_valid is a pure function of the FIFO occupancy and does not
// look at out_ready.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   in_valid     sample present on in_data
//   in_data      accumulator sample (unsigned, DATA_W)
//   in_ready     block can accept a sample this cycle (1 in COLLECT, 0 in STALL)
//   clear        synchronous abort of the partial window (ignored in STALL)
//   out_valid    FIFO head frame valid
//   out_ready    consumer takes the head frame
//   out_sum      head frame sum (SUM_W), 0 while the FIFO is empty
//   out_max      head frame maximum (DATA_W), 0 while the FIFO is empty
//   fifo_count   frames currently queued
//   frame_count  total frames pushed, wraps 255 -> 0
//
// The FSM state is held in state_q (type state_t) so checkers can bind to it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mac_window_collector #(
    parameter int DATA_W     = 18,
    parameter int WINDOW     = 4,
    parameter int SUM_W      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SUM_W-1:0]              out_sum,
    output logic [DATA_W-1:0]             out_max,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    frame_count
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [SUM_W-1:0]    pend_sum_q, pend_sum_d;
    logic [DATA_W-1:0]   pend_max_q, pend_max_d;

    logic [SUM_W-1:0]    mem_sum_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_max_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;
    logic [7:0]          frame_cnt_q;

    logic                accept;
    logic                pop;
    logic                fifo_full;
    logic                can_push;
    logic                last_sample;
    logic [SUM_W-1:0]    sample_sum;
    logic [DATA_W-1:0]   sample_max;
    logic                push;
    logic [SUM_W-1:0]    push_sum;
    logic [DATA_W-1:0]   push_max;

    assign in_ready    = (state_q == COLLECT);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign fifo_full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign can_push    = !fifo_full || pop;
    assign last_sample = (cnt_q == CNT_W'(WINDOW - 1));

    // Running totals including the sample on in_data this cycle.
    assign sample_sum  = sum_q + SUM_W'(in_data);
    assign sample_max  = (in_data > max_q) ? in_data : max_q;

    assign out_sum     = out_valid ? mem_sum_q[rd_ptr_q] : '0;
    assign out_max     = out_valid ? mem_max_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;
    assign frame_count = frame_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        max_d      = max_q;
        pend_sum_d = pend_sum_q;
        pend_max_d = pend_max_q;
        push       = 1'b0;
        push_sum   = '0;
        push_max   = '0;

        case (state_q)
            COLLECT: begin
                if (clear) begin
                    // clear wins over a same-cycle accept: that sample is dropped.
                    cnt_d = '0;
                    sum_d = '0;
                    max_d = '0;
                end else if (accept) begin
                    if (last_sample) begin
                        cnt_d = '0;
                        sum_d = '0;
                        max_d = '0;
                        if (can_push) begin
                            push     = 1'b1;
                            push_sum = sample_sum;
                            push_max = sample_max;
                        end else begin
                            pend_sum_d = sample_sum;
                            pend_max_d = sample_max;
                            state_d    = STALL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        sum_d = sample_sum;
                        max_d = sample_max;
                    end
                end
            end
            STALL: begin
                if (can_push) begin
                    push     = 1'b1;
                    push_sum = pend_sum_q;
                    push_max = pend_max_q;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            pend_sum_q  <= '0;
            pend_max_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_sum_q[i] <= '0;
                mem_max_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            pend_sum_q <= pend_sum_d;
            pend_max_q <= pend_max_d;
            count_q    <= count_d;
            if (push) begin
                mem_sum_q[wr_ptr_q] <= push_sum;
                mem_max_q[wr_ptr_q] <= push_max;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
                frame_cnt_q         <= frame_cnt_q + 8'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_window_collector.sv
`timescale 1ns/1ps
module tb_mac_window_collector;

    localparam int DATA_W     = 18;
    localparam int WINDOW     = 4;
    localparam int SUM_W      = 20;
    localparam int FIFO_DEPTH = 4;
    localparam int FW         = SUM_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic                clock;
    logic                reset;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic                clear;
    logic                out_valid;
    logic                out_ready;
    logic [SUM_W-1:0]    out_sum;
    logic [DATA_W-1:0]   out_max;
    logic [2:0]          fifo_count;
    logic [7:0]          frame_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mac_window_collector #(
        .DATA_W(DATA_W), .WINDOW(WINDOW), .SUM_W(SUM_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_max(out_max),
        .fifo_count(fifo_count), .frame_count(frame_count)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; the task returns at the next falling
    // edge, so outputs observed afterwards reflect the accepting rising edge.
    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Pops every queued frame, comparing each head against exp_q.
    task automatic drain(input string tag);
        logic [FW-1:0] e;
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_sum"}, 64'(out_sum), 64'(e[FW-1:DATA_W]));
            check({tag, "_max"}, 64'(out_max), 64'(e[DATA_W-1:0]));
            @(negedge clock);
        end
        out_ready = 1'b0;
        check({tag, "_empty_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_empty_sum"}, 64'(out_sum), 64'd0);
        check({tag, "_empty_count"}, 64'(fifo_count), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;

        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_max", 64'(out_max), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1) basic window 1,2,3,4 with consumer ready
        out_ready = 1'b1;
        send(18'd1);
        send(18'd2);
        send(18'd3);
        check("w1_not_yet", 64'(out_valid), 64'd0);
        send(18'd4);
        check("w1_valid", 64'(out_valid), 64'd1);
        check("w1_sum", 64'(out_sum), 64'd10);
        check("w1_max", 64'(out_max), 64'd4);
        check("w1_frames", 64'(frame_count), 64'd1);
        @(negedge clock);
        check("w1_drained", 64'(out_valid), 64'd0);
        check("w1_count0", 64'(fifo_count), 64'd0);

        // 2) full-scale samples: sum must not wrap
        for (int i = 0; i < 4; i++) send(18'h3FFFF);
        check("w2_sum", 64'(out_sum), 64'hFFFFC);
        check("w2_max", 64'(out_max), 64'h3FFFF);
        check("w2_frames", 64'(frame_count), 64'd2);
        @(negedge clock);
        out_ready = 1'b0;
        check("w2_drained", 64'(out_valid), 64'd0);

        // 3) fill the FIFO, fifth window stalls
        for (int w = 0; w < 4; w++) begin
            send(18'd10); send(18'd20); send(18'd30); send(18'd40);
            exp_q.push_back({20'd100, 18'd40});
        end
        check("fill_count", 64'(fifo_count), 64'd4);
        check("fill_frames", 64'(frame_count), 64'd6);
        send(18'd10); send(18'd20); send(18'd30);
        check("w5_ready_before", 64'(in_ready), 64'd1);
        send(18'd40);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_count", 64'(fifo_count), 64'd4);
        check("stall_frames", 64'(frame_count), 64'd6);
        // clear and a sample offered during STALL are both ignored
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 18'd999;
        @(negedge clock);
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        check("stall_hold_ready", 64'(in_ready), 64'd0);
        check("stall_hold_frames", 64'(frame_count), 64'd6);
        // one-cycle pop releases the pending frame
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({20'd100, 18'd40});
        check("release_count", 64'(fifo_count), 64'd4);
        check("release_frames", 64'(frame_count), 64'd7);
        check("release_ready", 64'(in_ready), 64'd1);

        // 4) full FIFO, last accept coincides with a pop: direct push
        send(18'd1); send(18'd2); send(18'd3);
        out_ready = 1'b1;
        send(18'd4);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({20'd10, 18'd4});
        check("direct_ready", 64'(in_ready), 64'd1);
        check("direct_count", 64'(fifo_count), 64'd4);
        check("direct_frames", 64'(frame_count), 64'd8);
        drain("drain4");

        // 5) clear aborts the partial window and drops its own sample
        send(18'd7);
        send(18'd9);
        clear = 1'b1;
        send(18'd100);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) send(18'd1);
        check("clr_count", 64'(fifo_count), 64'd1);
        check("clr_frames", 64'(frame_count), 64'd9);
        exp_q.push_back({20'd4, 18'd1});
        // keep it queued for the reset test; check head directly
        check("clr_sum", 64'(out_sum), 64'd4);
        check("clr_max", 64'(out_max), 64'd1);
        void'(exp_q.pop_front());

        // 6) asynchronous reset mid-cycle with 2 frames + 3 samples held
        send(18'd5); send(18'd5); send(18'd5); send(18'd5);
        send(18'd50); send(18'd60); send(18'd70);
        check("pre_rst_count", 64'(fifo_count), 64'd2);
        check("pre_rst_frames", 64'(frame_count), 64'd10);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_count", 64'(fifo_count), 64'd0);
        check("arst_frames", 64'(frame_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        send(18'd2); send(18'd2); send(18'd2); send(18'd2);
        check("post_rst_frames", 64'(frame_count), 64'd1);
        exp_q.push_back({20'd8, 18'd2});
        drain("post_rst");

        // out_ready high with nothing queued changes nothing
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        check("idle_count", 64'(fifo_count), 64'd0);
        check("idle_frames", 64'(frame_count), 64'd1);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
